// File: rtl/nexys_starship_pkg.sv
// Shared types and constants for the starship repair arbiter.
// Also holds TIMEOUT_TICKS, which only matters when REPAIR_TIMEOUT_EN is defined.
package nexys_starship_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WAIT  = 2'd2,
        CHECK = 2'd3
    } arb_state_t;

    localparam logic [1:0] TOP   = 2'd0;
    localparam logic [1:0] BTM   = 2'd1;
    localparam logic [1:0] LEFT  = 2'd2;
    localparam logic [1:0] RIGHT = 2'd3;

    localparam int TIMEOUT_TICKS = 8;
    localparam int TICK_W        = $clog2(TIMEOUT_TICKS + 1);

    function automatic logic [3:0] station_onehot(input logic [1:0] idx);
        station_onehot = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/nexys_starship_rr_picker.sv
// Round-robin station picker: first requesting station after 'last', wrapping 3->0.
// 'last' itself is the lowest-priority candidate.
module nexys_starship_rr_picker
    import nexys_starship_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] idx,
    output logic       valid
);

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        idx   = last;
        valid = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            if (req[last + 2'(i)]) begin
                idx   = last + 2'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nexys_starship_repair_arb.sv
// Repair arbiter: grants the keypad/SSD to one broken station at a time, checks the combo.
// Define REPAIR_TIMEOUT_EN to release a grant after TIMEOUT_TICKS timer ticks in WAIT.
module nexys_starship_repair_arb
    import nexys_starship_pkg::*;
(
    input  logic       board_clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic       gameover_ctrl,
    input  logic [3:0] broken,
    input  logic [3:0] random_hex,
    input  logic [3:0] hex_combo,
    input  logic       submit_pulse,
    input  logic       timer_tick,
    output logic [3:0] grant,
    output logic [3:0] challenge,
    output logic [3:0] repair_done,
    output logic       wrong_pulse,
    output logic       repair_timeout
);

    arb_state_t state_reg;
    logic [1:0] sel_reg;
    logic [1:0] last_served_reg;
    logic [3:0] grant_reg;
    logic [3:0] challenge_reg;
    logic [3:0] combo_reg;
    logic [3:0] repair_done_reg;
    logic       wrong_pulse_reg;
    logic [1:0] pick_idx;
    logic       pick_valid;
    logic       timeout_hit;

    nexys_starship_rr_picker u_picker (
        .req   (broken),
        .last  (last_served_reg),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef REPAIR_TIMEOUT_EN
    logic [TICK_W-1:0] tick_count_reg;
    logic              timeout_reg;

    // Outside WAIT the count sits at zero, so every entry into WAIT starts fresh.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset)
            tick_count_reg <= '0;
        else if (state_reg != WAIT)
            tick_count_reg <= '0;
        else if (timer_tick)
            tick_count_reg <= tick_count_reg + 1'b1;
    end

    assign timeout_hit    = (state_reg == WAIT) && timer_tick &&
                            (tick_count_reg == TICK_W'(TIMEOUT_TICKS - 1));
    assign repair_timeout = timeout_reg;
`else
    logic unused_tick;
    assign unused_tick    = timer_tick;
    assign timeout_hit    = 1'b0;
    assign repair_timeout = 1'b0;
`endif

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_reg       <= IDLE;
            sel_reg         <= TOP;
            last_served_reg <= RIGHT;
            grant_reg       <= '0;
            challenge_reg   <= '0;
            combo_reg       <= '0;
            repair_done_reg <= '0;
            wrong_pulse_reg <= 1'b0;
`ifdef REPAIR_TIMEOUT_EN
            timeout_reg     <= 1'b0;
`endif
        end else begin
            repair_done_reg <= '0;
            wrong_pulse_reg <= 1'b0;
`ifdef REPAIR_TIMEOUT_EN
            timeout_reg     <= 1'b0;
`endif
            if (gameover_ctrl || !play_flag) begin
                state_reg <= IDLE;
                grant_reg <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (pick_valid) begin
                            sel_reg   <= pick_idx;
                            state_reg <= LOAD;
                        end
                    end
                    LOAD: begin
                        grant_reg     <= station_onehot(sel_reg);
                        challenge_reg <= random_hex;
                        state_reg     <= WAIT;
                    end
                    WAIT: begin
                        if (!broken[sel_reg]) begin
                            last_served_reg <= sel_reg;
                            grant_reg       <= '0;
                            state_reg       <= IDLE;
                        end else if (submit_pulse) begin
                            combo_reg <= hex_combo;
                            state_reg <= CHECK;
                        end else if (timeout_hit) begin
                            last_served_reg <= sel_reg;
                            grant_reg       <= '0;
                            state_reg       <= IDLE;
`ifdef REPAIR_TIMEOUT_EN
                            timeout_reg     <= 1'b1;
`endif
                        end
                    end
                    CHECK: begin
                        if (!broken[sel_reg]) begin
                            last_served_reg <= sel_reg;
                            grant_reg       <= '0;
                            state_reg       <= IDLE;
                        end else if (combo_reg == challenge_reg) begin
                            repair_done_reg <= grant_reg;
                            last_served_reg <= sel_reg;
                            grant_reg       <= '0;
                            state_reg       <= IDLE;
                        end else begin
                            wrong_pulse_reg <= 1'b1;
                            state_reg       <= WAIT;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign grant       = grant_reg;
    assign challenge   = challenge_reg;
    assign repair_done = repair_done_reg;
    assign wrong_pulse = wrong_pulse_reg;

endmodule

// File: tb/tb_nexys_starship_repair_arb.sv
// Directed bench for nexys_starship_repair_arb; checks depend on whether REPAIR_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_nexys_starship_repair_arb;

    logic       board_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       play_flag = 1'b0;
    logic       gameover_ctrl = 1'b0;
    logic [3:0] broken = 4'h0;
    logic [3:0] random_hex = 4'h0;
    logic [3:0] hex_combo = 4'h0;
    logic       submit_pulse = 1'b0;
    logic       timer_tick = 1'b0;
    logic [3:0] grant;
    logic [3:0] challenge;
    logic [3:0] repair_done;
    logic       wrong_pulse;
    logic       repair_timeout;

    int checks = 0;
    int fails  = 0;

    nexys_starship_repair_arb dut (
        .board_clk      (board_clk),
        .Reset          (Reset),
        .play_flag      (play_flag),
        .gameover_ctrl  (gameover_ctrl),
        .broken         (broken),
        .random_hex     (random_hex),
        .hex_combo      (hex_combo),
        .submit_pulse   (submit_pulse),
        .timer_tick     (timer_tick),
        .grant          (grant),
        .challenge      (challenge),
        .repair_done    (repair_done),
        .wrong_pulse    (wrong_pulse),
        .repair_timeout (repair_timeout)
    );

    always #5 board_clk = ~board_clk;

    task automatic step();
        @(posedge board_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_done"}, repair_done, 4'h0);
        check({tag, "_wrong"}, {3'b0, wrong_pulse}, 4'h0);
        check({tag, "_tmo"}, {3'b0, repair_timeout}, 4'h0);
    endtask

    logic [3:0] exp_grant [5];

    initial begin
        exp_grant[0] = 4'b0001;
        exp_grant[1] = 4'b0010;
        exp_grant[2] = 4'b0100;
        exp_grant[3] = 4'b1000;
        exp_grant[4] = 4'b0001;

        // Reset state
        step(); step();
        check("rst_grant", grant, 4'h0);
        check("rst_challenge", challenge, 4'h0);
        check_quiet("rst");
        Reset = 1'b0;

        // First grant: top, 2-cycle latency, challenge captured
        play_flag = 1'b1; broken = 4'b0101; random_hex = 4'hA;
        step();
        check("lat_grant_c1", grant, 4'h0);
        step();
        check("first_grant", grant, 4'b0001);
        check("first_challenge", challenge, 4'hA);
        random_hex = 4'h7;

        // Wrong combo
        hex_combo = 4'h3; submit_pulse = 1'b1;
        step();
        submit_pulse = 1'b0;
        check("wrong_c1", {3'b0, wrong_pulse}, 4'h0);
        step();
        check("wrong_pulse", {3'b0, wrong_pulse}, 4'h1);
        check("wrong_grant_held", grant, 4'b0001);
        check("wrong_chal_held", challenge, 4'hA);
        step();
        check("wrong_one_cycle", {3'b0, wrong_pulse}, 4'h0);

        // Correct combo
        hex_combo = 4'hA; submit_pulse = 1'b1;
        step();
        submit_pulse = 1'b0;
        step();
        check("done_top", repair_done, 4'b0001);
        check("done_grant_clr", grant, 4'h0);
        check("done_no_wrong", {3'b0, wrong_pulse}, 4'h0);
        broken = 4'b0100; random_hex = 4'h5;
        step();
        check("done_one_cycle", repair_done, 4'h0);

        // Submit during LOAD->WAIT is ignored even though it matches
        hex_combo = 4'h5; submit_pulse = 1'b1;
        step();
        submit_pulse = 1'b0;
        check("next_grant_left", grant, 4'b0100);
        check("next_challenge", challenge, 4'h5);
        step(); step();
        check_quiet("load_submit");
        check("load_submit_grant", grant, 4'b0100);

        // Game over in WAIT
        gameover_ctrl = 1'b1;
        step();
        check("gameover_grant", grant, 4'h0);
        submit_pulse = 1'b1;
        step();
        submit_pulse = 1'b0;
        step();
        check_quiet("gameover_submit");
        check("gameover_grant2", grant, 4'h0);
        broken = 4'h0;
        gameover_ctrl = 1'b0;
        step();

        // Asynchronous reset takes effect without a clock edge
        @(negedge board_clk);
        Reset = 1'b1;
        #1;
        check("async_rst_grant", grant, 4'h0);
        step();
        Reset = 1'b0;

        // Full rotation with all stations broken
        broken = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            random_hex = 4'(k + 2);
            step(); step();
            check($sformatf("rot%0d_grant", k), grant, exp_grant[k]);
            check($sformatf("rot%0d_chal", k), challenge, 4'(k + 2));
            hex_combo = 4'(k + 2); submit_pulse = 1'b1;
            step();
            submit_pulse = 1'b0;
            step();
            check($sformatf("rot%0d_done", k), repair_done, exp_grant[k]);
        end

        // Station 1 granted, then its broken flag drops
        broken = 4'b0011; random_hex = 4'hC;
        step(); step();
        check("drop_grant_btm", grant, 4'b0010);
        broken = 4'b0001;
        step();
        check("drop_grant_clr", grant, 4'h0);
        check_quiet("drop");
        step();
        check("drop_no_done", repair_done, 4'h0);
        step();
        check("drop_next_top", grant, 4'b0001);

        // Timer ticks while waiting on station 0
        broken = 4'b0011;
`ifdef REPAIR_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            timer_tick = 1'b1;
            step();
            timer_tick = 1'b0;
            if (i == 8) begin
                check("tmo_pulse", {3'b0, repair_timeout}, 4'h1);
                check("tmo_grant_clr", grant, 4'h0);
            end else begin
                check($sformatf("tmo_wait%0d", i), {3'b0, repair_timeout}, 4'h0);
                check($sformatf("tmo_held%0d", i), grant, 4'b0001);
            end
            step();
        end
        check("tmo_one_cycle", {3'b0, repair_timeout}, 4'h0);
        step();
        check("tmo_rotate_btm", grant, 4'b0010);
`else
        for (int i = 1; i <= 20; i++) begin
            timer_tick = 1'b1;
            step();
            timer_tick = 1'b0;
            check($sformatf("notmo_%0d", i), {3'b0, repair_timeout}, 4'h0);
            step();
        end
        check("notmo_grant_held", grant, 4'b0001);
`endif

        // Play flag dropping aborts the grant
        play_flag = 1'b0;
        step();
        check("noplay_grant", grant, 4'h0);
        check_quiet("noplay");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
